lane_gearbox: RTL and testbench
===============================

// Module: lane_gearbox
// PURPOSE
//  Per-lane width converter downstream of the 16-lane distributor (lanes) in the 1.6T AUI TX chain.
//  Accepts one LANE_WIDTH codeword-interleaved lane word (lane_N + sync_lane_N) and emits it as RATIO
//  OUT_WIDTH-bit chunks over a valid/ready stream toward the PMA serializer.
//  Double-buffered (ping-pong) so a new lane word can be accepted while the previous one drains.
//  Instantiated 16 times, one per lane.
// PARAMETERS
//  LANE_WIDTH  1360  input lane word width (bits)
//  OUT_WIDTH   136   output chunk width (bits); LANE_WIDTH % OUT_WIDTH must be 0 (elaboration $error otherwise)
//  RATIO       LANE_WIDTH/OUT_WIDTH (localparam, 10 by default); chunks per lane word
// PORTS
//  clk         in   1           single clock, all logic on posedge
//  rst         in   1           synchronous, active-high reset
//  i_valid     in   1           lane word present on i_lane (lanes valid)
//  i_lane      in   LANE_WIDTH  lane word (o_lane_N)
//  i_sync      in   1           sync flag for this word (sync_lane_N)
//  o_ready     out  1           word accepted this cycle if i_valid=1
//  o_valid     out  1           o_data holds a valid chunk
//  i_ready     in   1           downstream accepts chunk when o_valid & i_ready
//  o_data      out  OUT_WIDTH   current chunk
//  o_sof       out  1           chunk is chunk 0 of its lane word
//  o_sync      out  1           o_sof & stored sync flag of that word
//  o_overflow  out  1           sticky: a word arrived while o_ready=0 (word dropped)
// BEHAVIOUR
//  - Storage: two entries {word[LANE_WIDTH], sync}; rd_ptr, wr_ptr (1 bit each), occ (0..2),
//    chunk counter cnt (0..RATIO-1).
//  - Reset (rst=1 at posedge): occ=0, rd_ptr=wr_ptr=0, cnt=0, o_overflow=0. Inputs are ignored while rst=1.
//    Word data registers are not reset.
//  - Reset outputs: o_valid=0, o_sof=0, o_sync=0, o_overflow=0, o_ready=1. o_data is don't-care and must be
//    driven 0 when o_valid=0.
//  - o_ready = (occ != 2); combinational from occ only, with no path from i_valid/i_ready.
//  - Accept: i_valid & o_ready & !rst -> entry[wr_ptr] <= {i_lane, i_sync}; wr_ptr toggles.
//  - o_valid = (occ != 0). o_data = entry[rd_ptr].word[cnt*OUT_WIDTH +: OUT_WIDTH], LSB chunk first.
//  - o_sof = o_valid & (cnt==0); o_sync = o_sof & entry[rd_ptr].sync.
//  - Latency: a word accepted at edge N has its chunk 0 on o_data from edge N+1 (occ was 0).
//    Chunk k is shown on o_valid & i_ready cycles; the minimum is RATIO cycles per word.
//  - Transfer: o_valid & i_ready -> cnt+1. At cnt==RATIO-1: cnt<=0, rd_ptr toggles (word retired).
//  - Holding: o_valid & !i_ready -> o_data, o_sof, o_sync, cnt and rd_ptr are held stable (no chunk skipped or altered).
//  - occ update: +1 on accept only; -1 on retire only; unchanged on simultaneous accept+retire.
//    The occ==2 retire cycle still reports o_ready=0; the freed slot is visible the next cycle.
//  - Overflow: i_valid & !o_ready & !rst -> word discarded, o_overflow<=1. Held until rst.
//    Storage and pointers are not disturbed.
//  - Full throughput: upstream words every RATIO cycles with i_ready=1 never overflow.
//    Steady occ alternates 1/2 at most.
//  - Reset mid-word: the partially sent word and the buffered word are dropped. The next post-reset word
//    starts at cnt=0 with o_sof=1.
// TESTING
//  1. Reset, then one word with chunk k = 136'(k+1), i_sync=1, i_ready=1 ->
//     o_valid for 10 cycles starting 1 cycle after accept; o_data=1..10; o_sof & o_sync only on the first; o_ready=1 throughout.
//  2. Back-to-back words A,B,C on consecutive cycles, i_ready=1 -> A,B accepted; C rejected (o_ready=0);
//     o_overflow=1 from the next cycle; output = 10 chunks of A then 10 of B, gap-free.
//  3. Word every 10 cycles for 50 words, i_ready=1 -> 500 contiguous valid chunks, o_overflow stays 0,
//     o_sof every 10th chunk, data matches scoreboard.
//  4. i_ready toggled 1,0,0,1 pattern (random seed fixed) during a word ->
//     o_data/o_sof held while i_ready=0; exactly 10 handshakes per word, order 0..9 preserved.
//  5. Assert rst for 1 cycle after chunk 4 of a word, with a second word buffered ->
//     next cycle o_valid=0, o_ready=1, o_overflow=0; a new word restarts at chunk 0 with o_sof=1.
//  6. Simultaneous accept and retire with occ=1 (new word on the cycle of chunk 9 handshake) ->
//     occ stays 1; the new word's chunk 0 appears the very next cycle, no bubble.

Source files
------------

// File: rtl/lane_gearbox.sv
// rtl/lane_gearbox.sv - per-lane ping-pong width converter, one lane word out as RATIO chunks
// Two-entry store with chunk counter; the next word can land while the current one drains.
module lane_gearbox #(
   parameter int LANE_WIDTH = 1360,
   parameter int OUT_WIDTH  = 136
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_valid,
   input  logic [LANE_WIDTH-1:0] i_lane,
   input  logic                  i_sync,
   output logic                  o_ready,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [OUT_WIDTH-1:0]  o_data,
   output logic                  o_sof,
   output logic                  o_sync,
   output logic                  o_overflow
);

   localparam int RATIO = LANE_WIDTH / OUT_WIDTH;
   localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

   generate
      if (LANE_WIDTH % OUT_WIDTH != 0) begin : g_bad_ratio
         $error("lane_gearbox: LANE_WIDTH must be a multiple of OUT_WIDTH");
      end
   endgenerate

   typedef logic [RATIO-1:0][OUT_WIDTH-1:0] word_t;

   word_t            word_q [2];
   logic             sync_q [2];
   logic             rd_ptr_q, rd_ptr_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic [1:0]       occ_q, occ_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             accept, xfer, retire;

   // o_ready/o_valid depend on occupancy alone so no combinational path crosses the block
   assign o_ready    = (occ_q != 2'd2);
   assign o_valid    = (occ_q != 2'd0);
   assign o_data     = o_valid ? word_q[rd_ptr_q][cnt_q] : '0;
   assign o_sof      = o_valid & (cnt_q == '0);
   assign o_sync     = o_sof & sync_q[rd_ptr_q];
   assign o_overflow = ovf_q;

   always_comb begin
      accept   = i_valid & o_ready;
      xfer     = o_valid & i_ready;
      retire   = xfer & (cnt_q == CNT_LAST);
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      occ_d    = occ_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q | (i_valid & ~o_ready);

      if (accept) begin
         wr_ptr_d = ~wr_ptr_q;
      end
      if (xfer) begin
         cnt_d = retire ? '0 : cnt_q + CNT_W'(1);
      end
      if (retire) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({accept, retire})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         occ_q    <= occ_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
      end
   end

   // Word storage is not reset; stale contents are unreachable while occ is 0
   always_ff @(posedge clk) begin
      if (!rst && accept) begin
         word_q[wr_ptr_q] <= i_lane;
         sync_q[wr_ptr_q] <= i_sync;
      end
   end

endmodule

// File: tb/tb_lane_gearbox.sv
// tb/tb_lane_gearbox.sv - directed self-checking bench for lane_gearbox
// Expected chunks are queued by the bench per accepted word and checked on each handshake.
module tb_lane_gearbox;

   localparam int LW = 1360;
   localparam int OW = 136;
   localparam int R  = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_valid;
   logic [LW-1:0] i_lane;
   logic          i_sync;
   logic          o_ready;
   logic          o_valid;
   logic          i_ready;
   logic [OW-1:0] o_data;
   logic          o_sof;
   logic          o_sync;
   logic          o_overflow;

   typedef struct packed {
      logic [OW-1:0] d;
      logic          sof;
      logic          sync;
   } exp_t;

   exp_t          exp_q[$];
   int            checks   = 0;
   int            failures = 0;
   int            hs_cnt   = 0;
   logic          hold_pend = 1'b0;
   logic [OW-1:0] hold_d;
   logic          hold_sof, hold_sync;
   logic [3:0]    pat = 4'b1001;

   lane_gearbox #(.LANE_WIDTH(LW), .OUT_WIDTH(OW)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_valid    (i_valid),
      .i_lane     (i_lane),
      .i_sync     (i_sync),
      .o_ready    (o_ready),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_data     (o_data),
      .o_sof      (o_sof),
      .o_sync     (o_sync),
      .o_overflow (o_overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, want);
      end
   endtask

   function automatic logic [LW-1:0] make_word(input int base);
      logic [LW-1:0] w;
      for (int k = 0; k < R; k++) w[k*OW +: OW] = OW'(base + k);
      return w;
   endfunction

   task automatic push_word(input int base, input logic s);
      exp_t e;
      for (int k = 0; k < R; k++) begin
         e.d    = OW'(base + k);
         e.sof  = (k == 0);
         e.sync = (k == 0) & s;
         exp_q.push_back(e);
      end
   endtask

   task automatic drive_word(input int base, input logic s);
      i_valid = 1'b1;
      i_lane  = make_word(base);
      i_sync  = s;
   endtask

   task automatic idle();
      i_valid = 1'b0;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      i_valid = 1'b0;
      i_ready = 1'b1;
      sample();
      next();
      rst = 1'b0;
      exp_q.delete();
   endtask

   // Handshake scoreboard and stall-stability monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (hold_pend && !rst) begin
            check("hold_data", o_data, hold_d);
            check("hold_sof", o_sof, hold_sof);
            check("hold_sync", o_sync, hold_sync);
         end
         if (o_valid === 1'b1 && i_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_chunk", o_data, '0 - 1);
            end else begin
               e = exp_q.pop_front();
               check("chunk_data", o_data, e.d);
               check("chunk_sof", o_sof, e.sof);
               check("chunk_sync", o_sync, e.sync);
               hs_cnt++;
            end
         end
         hold_pend = (o_valid === 1'b1) && (i_ready === 1'b0);
         hold_d    = o_data;
         hold_sof  = o_sof;
         hold_sync = o_sync;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   initial begin
      rst     = 1'b1;
      i_valid = 1'b0;
      i_lane  = '0;
      i_sync  = 1'b0;
      i_ready = 1'b1;
      next();
      next();
      rst = 1'b0;

      sample();
      check("rst_valid", o_valid, 0);
      check("rst_sof", o_sof, 0);
      check("rst_sync", o_sync, 0);
      check("rst_ovf", o_overflow, 0);
      check("rst_ready", o_ready, 1);
      check("rst_data", o_data, 0);
      next();

      // single word, chunk k = k+1
      drive_word(1, 1'b1);
      push_word(1, 1'b1);
      sample();
      check("t1_ready_acc", o_ready, 1);
      check("t1_valid_pre", o_valid, 0);
      next();
      idle();
      for (int c = 0; c < R; c++) begin
         sample();
         check("t1_valid", o_valid, 1);
         check("t1_ready", o_ready, 1);
         next();
      end
      sample();
      check("t1_valid_end", o_valid, 0);
      check("t1_drained", exp_q.size(), 0);
      next();

      // back-to-back A,B,C: C dropped
      drive_word(100, 1'b0);
      push_word(100, 1'b0);
      sample();
      check("t2_ready_a", o_ready, 1);
      next();
      drive_word(200, 1'b1);
      push_word(200, 1'b1);
      sample();
      check("t2_ready_b", o_ready, 1);
      check("t2_valid_b", o_valid, 1);
      next();
      drive_word(300, 1'b1);
      sample();
      check("t2_ready_full", o_ready, 0);
      check("t2_ovf_pre", o_overflow, 0);
      next();
      idle();
      sample();
      check("t2_ovf_set", o_overflow, 1);
      check("t2_ready_full2", o_ready, 0);
      check("t2_valid_c3", o_valid, 1);
      next();
      for (int c = 4; c <= 2*R; c++) begin
         sample();
         check("t2_valid_gapfree", o_valid, 1);
         check("t2_ovf_sticky", o_overflow, 1);
         next();
      end
      sample();
      check("t2_valid_end", o_valid, 0);
      check("t2_ready_end", o_ready, 1);
      check("t2_ovf_end", o_overflow, 1);
      check("t2_drained", exp_q.size(), 0);
      next();

      // 50 words at full rate
      do_reset();
      for (int n = 0; n < 50; n++) begin
         drive_word(1000 * (n + 1), n[0]);
         push_word(1000 * (n + 1), n[0]);
         sample();
         check("t3_ready", o_ready, 1);
         if (n > 0) check("t3_valid_acc", o_valid, 1);
         next();
         idle();
         for (int c = 0; c < R - 1; c++) begin
            sample();
            check("t3_valid", o_valid, 1);
            next();
         end
      end
      sample();
      check("t3_valid_last", o_valid, 1);
      next();
      sample();
      check("t3_valid_end", o_valid, 0);
      check("t3_ovf", o_overflow, 0);
      check("t3_drained", exp_q.size(), 0);
      next();

      // backpressure 1,0,0,1
      do_reset();
      drive_word(5000, 1'b1);
      push_word(5000, 1'b1);
      sample();
      next();
      idle();
      hs_cnt = 0;
      for (int c = 0; c < 60 && hs_cnt < R; c++) begin
         i_ready = pat[c % 4];
         sample();
         next();
      end
      i_ready = 1'b1;
      sample();
      check("t4_handshakes", hs_cnt, R);
      check("t4_valid_end", o_valid, 0);
      check("t4_drained", exp_q.size(), 0);
      next();

      // reset mid-word with a second word buffered
      do_reset();
      drive_word(7000, 1'b0);
      push_word(7000, 1'b0);
      sample();
      next();
      drive_word(8000, 1'b1);
      sample();
      check("t5_ready_b", o_ready, 1);
      next();
      idle();
      for (int c = 2; c <= 5; c++) begin
         sample();
         next();
      end
      rst = 1'b1;
      drive_word(8500, 1'b1);
      sample();
      check("t5_ready_full", o_ready, 0);
      next();
      rst = 1'b0;
      idle();
      exp_q.delete();
      sample();
      check("t5_valid", o_valid, 0);
      check("t5_ready", o_ready, 1);
      check("t5_ovf", o_overflow, 0);
      check("t5_sof", o_sof, 0);
      next();
      drive_word(9500, 1'b1);
      push_word(9500, 1'b1);
      sample();
      next();
      idle();
      sample();
      check("t5_new_sof", o_sof, 1);
      check("t5_new_data", o_data, 9500);
      next();
      for (int c = 1; c < R; c++) begin
         sample();
         next();
      end
      sample();
      check("t5_valid_end", o_valid, 0);
      check("t5_drained", exp_q.size(), 0);
      next();

      // accept on the retire cycle with occ=1
      do_reset();
      drive_word(11000, 1'b0);
      push_word(11000, 1'b0);
      sample();
      next();
      idle();
      for (int c = 1; c < R; c++) begin
         sample();
         check("t6_valid_p", o_valid, 1);
         next();
      end
      drive_word(12000, 1'b1);
      push_word(12000, 1'b1);
      sample();
      check("t6_ready_occ1", o_ready, 1);
      check("t6_last_chunk", o_data, 11009);
      next();
      idle();
      sample();
      check("t6_valid_nobubble", o_valid, 1);
      check("t6_sof", o_sof, 1);
      check("t6_sync", o_sync, 1);
      check("t6_ready_still", o_ready, 1);
      next();
      for (int c = 1; c < R; c++) begin
         sample();
         check("t6_valid_q", o_valid, 1);
         next();
      end
      sample();
      check("t6_valid_end", o_valid, 0);
      check("t6_drained", exp_q.size(), 0);
      check("t6_ovf", o_overflow, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
